score_controller: RTL and testbench

- Sequences a game of Pong. Detects a miss at each side and keeps a two-digit BCD score for each player.
- Times the serve pause in video frames, declares a winner, and gates the score display.
- Sits between ball/collision logic and the scores_display datapath. It drives the digit values that datapath renders and an enable that blanks or blinks it.

---
 rtl/score_controller.sv | 181 ++++++++++++++++++
 tb/tb_score_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/score_controller.sv
// Pong score sequencer: serve timing, BCD scoring and winner detection for two players.
// Define SCORE_BLINK_EN to blink the score display while the game is over.
module score_controller #(
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [3:0] score_left_tens,
    output logic [3:0] score_left_units,
    output logic [3:0] score_right_tens,
    output logic [3:0] score_right_units,
    output logic       score_enable,
    output logic       ball_release,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

    localparam logic [6:0] WIN_BIN   = 7'(WIN_SCORE);
    localparam logic [7:0] SERVE_CNT = 8'(SERVE_FRAMES);

    state_t     state, state_n;
    logic       vsync_q, start_q, miss_left_q, miss_right_q;
    logic       tick, start_ev, left_ev, right_ev;
    logic [7:0] score_l, score_l_n, score_r, score_r_n;  // {tens, units}
    logic [7:0] frames, frames_n;
    logic       dir, dir_n, win, win_n;
`ifdef SCORE_BLINK_EN
    logic [5:0] blink, blink_n;
`endif

    // Saturating two-digit BCD increment.
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        logic [7:0] r;
        if (s == 8'h99)
            r = s;
        else if (s[3:0] == 4'd9)
            r = {s[7:4] + 4'd1, 4'd0};
        else
            r = {s[7:4], s[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [6:0] bcd_val(input logic [7:0] s);
        return 7'(s[7:4]) * 7'd10 + 7'(s[3:0]);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q      <= 1'b0;
            start_q      <= 1'b0;
            miss_left_q  <= 1'b0;
            miss_right_q <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            start_q      <= start;
            miss_left_q  <= miss_left;
            miss_right_q <= miss_right;
        end
    end

    assign tick     = vsync & ~vsync_q;
    assign start_ev = start & ~start_q;
    assign left_ev  = miss_left & ~miss_left_q;
    assign right_ev = miss_right & ~miss_right_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            score_l <= 8'h00;
            score_r <= 8'h00;
            frames  <= 8'd0;
            dir     <= 1'b0;
            win     <= 1'b0;
`ifdef SCORE_BLINK_EN
            blink   <= 6'd0;
`endif
        end else begin
            state   <= state_n;
            score_l <= score_l_n;
            score_r <= score_r_n;
            frames  <= frames_n;
            dir     <= dir_n;
            win     <= win_n;
`ifdef SCORE_BLINK_EN
            blink   <= blink_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        score_l_n = score_l;
        score_r_n = score_r;
        frames_n  = frames;
        dir_n     = dir;
        win_n     = win;
`ifdef SCORE_BLINK_EN
        blink_n   = blink;
`endif
        // A start press restarts the game from any state.
        if (start_ev) begin
            state_n   = SERVE;
            score_l_n = 8'h00;
            score_r_n = 8'h00;
            frames_n  = 8'd0;
            dir_n     = 1'b1;
            win_n     = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                SERVE: begin
                    if (tick) begin
                        frames_n = frames + 8'd1;
                        if (frames + 8'd1 == SERVE_CNT)
                            state_n = PLAY;
                    end
                end
                PLAY: begin
                    // miss_left wins when both sides miss in the same cycle.
                    if (left_ev) begin
                        score_r_n = bcd_inc(score_r);
                        dir_n     = 1'b0;
                        if (bcd_val(bcd_inc(score_r)) == WIN_BIN) begin
                            state_n = OVER;
                            win_n   = 1'b1;
`ifdef SCORE_BLINK_EN
                            blink_n = 6'd0;
`endif
                        end else begin
                            state_n  = SERVE;
                            frames_n = 8'd0;
                        end
                    end else if (right_ev) begin
                        score_l_n = bcd_inc(score_l);
                        dir_n     = 1'b1;
                        if (bcd_val(bcd_inc(score_l)) == WIN_BIN) begin
                            state_n = OVER;
                            win_n   = 1'b0;
`ifdef SCORE_BLINK_EN
                            blink_n = 6'd0;
`endif
                        end else begin
                            state_n  = SERVE;
                            frames_n = 8'd0;
                        end
                    end
                end
                OVER: begin
`ifdef SCORE_BLINK_EN
                    if (tick)
                        blink_n = blink + 6'd1;
`endif
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign score_left_tens   = score_l[7:4];
    assign score_left_units  = score_l[3:0];
    assign score_right_tens  = score_r[7:4];
    assign score_right_units = score_r[3:0];
    assign ball_release      = (state == PLAY);
    assign game_over         = (state == OVER);
    assign serve_dir         = dir;
    assign winner            = win;
`ifdef SCORE_BLINK_EN
    assign score_enable      = !((state == OVER) && blink[5]);
`else
    assign score_enable      = 1'b1;
`endif

endmodule

// File: tb/tb_score_controller.sv
// Randomized scoreboard bench for score_controller against an integer-score game model.
module tb_score_controller;

    logic clk = 1'b0, reset = 1'b1, vsync = 1'b0, start = 1'b0;
    logic miss_left = 1'b0, miss_right = 1'b0;
    logic [3:0] score_left_tens, score_left_units, score_right_tens, score_right_units;
    logic score_enable, ball_release, serve_dir, game_over, winner;

    int checks = 0, errors = 0;

    score_controller #(.WIN_SCORE(11), .SERVE_FRAMES(60)) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .start(start),
        .miss_left(miss_left), .miss_right(miss_right),
        .score_left_tens(score_left_tens), .score_left_units(score_left_units),
        .score_right_tens(score_right_tens), .score_right_units(score_right_units),
        .score_enable(score_enable), .ball_release(ball_release), .serve_dir(serve_dir),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    // Frame ticks with a randomly varying period.
    initial forever begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        vsync = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        vsync = 1'b0;
    end

    // Reference game: 0 idle, 1 serve, 2 play, 3 over; scores held as integers.
    int m_state = 0, m_left = 0, m_right = 0, m_frames = 0, m_blink = 0;
    bit m_dir = 0, m_win = 0;
    bit p_v = 0, p_s = 0, p_l = 0, p_r = 0;
    logic [20:0] q[$];

    task mreset;
        m_state = 0; m_left = 0; m_right = 0; m_frames = 0; m_blink = 0;
        m_dir = 0; m_win = 0; p_v = 0; p_s = 0; p_l = 0; p_r = 0;
    endtask

    task award(input bit to_right);
        if (to_right) begin
            m_right = (m_right < 99) ? m_right + 1 : 99;
            m_dir = 0;
        end else begin
            m_left = (m_left < 99) ? m_left + 1 : 99;
            m_dir = 1;
        end
        if ((to_right ? m_right : m_left) == 11) begin
            m_state = 3; m_win = to_right; m_blink = 0;
        end else begin
            m_state = 1; m_frames = 0;
        end
    endtask

    task mstep;
        bit ev_v, ev_s, ev_l, ev_r;
        ev_v = vsync && !p_v; ev_s = start && !p_s;
        ev_l = miss_left && !p_l; ev_r = miss_right && !p_r;
        p_v = vsync; p_s = start; p_l = miss_left; p_r = miss_right;
        if (ev_s) begin
            m_state = 1; m_left = 0; m_right = 0; m_frames = 0; m_dir = 1; m_win = 0;
        end else if (m_state == 1 && ev_v) begin
            m_frames++;
            if (m_frames == 60) m_state = 2;
        end else if (m_state == 2 && ev_l) award(1);
        else if (m_state == 2 && ev_r) award(0);
        else if (m_state == 3 && ev_v) m_blink = (m_blink + 1) % 64;
    endtask

    function automatic logic [20:0] mexp();
        logic en;
`ifdef SCORE_BLINK_EN
        en = !(m_state == 3 && m_blink >= 32);
`else
        en = 1'b1;
`endif
        return {4'(m_left / 10), 4'(m_left % 10), 4'(m_right / 10), 4'(m_right % 10),
                en, m_state == 2, m_dir, m_state == 3, m_win};
    endfunction

    function automatic logic [20:0] actual();
        return {score_left_tens, score_left_units, score_right_tens, score_right_units,
                score_enable, ball_release, serve_dir, game_over, winner};
    endfunction

    always @(posedge clk) begin
        if (reset) mreset();
        else mstep();
        q.push_back(mexp());
    end

    always @(posedge reset) mreset();

    // Monitor: every cycle the DUT outputs are compared with the queued expectation.
    always @(negedge clk) begin : monitor
        logic [20:0] e, a;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = q.pop_front();
            a = actual();
            if (!e[1]) begin a[0] = 1'b0; e[0] = 1'b0; end
            if (a !== e) begin
                errors++;
                $display("FAIL outputs at %0t got %h expected %h", $time, a, e);
            end
        end
    end

    task pulse_start;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Wait for the ball to be released; optionally throw misses during SERVE.
    task wait_play(input bit noisy);
        int n;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (m_state == 2) break;
            if (noisy && m_state == 1) begin
                miss_left  = ($urandom % 6 == 0);
                miss_right = ($urandom % 6 == 0);
            end
            n++;
        end
        miss_left = 1'b0; miss_right = 1'b0;
        if (m_state != 2) begin
            checks++; errors++;
            $display("FAIL wait_play_timeout state %0d expected 2", m_state);
        end
    endtask

    // side 0: left misses, 1: right misses, 2: both in the same cycle
    task point(input int side);
        wait_play(1'b1);
        @(negedge clk);
        miss_left  = (side != 1);
        miss_right = (side != 0);
        @(negedge clk);
        miss_left = 1'b0; miss_right = 1'b0;
    endtask

    initial begin
        int l, r, n;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Game 1: left scores every point, through the 9 -> 10 carry to 11.
        pulse_start;
        for (int i = 0; i < 11; i++) point(1);
        repeat (20) begin
            @(negedge clk);
            miss_left = 1'($urandom % 2); miss_right = 1'($urandom % 2);
        end
        miss_left = 1'b0; miss_right = 1'b0;

        // Game 2: simultaneous misses, a restart in PLAY, then 05/07 and async reset.
        pulse_start;
        point(0);
        point(2);
        wait_play(1'b0);
        pulse_start;
        l = 5; r = 7;
        while (l + r > 0) begin
            if (int'($urandom % (l + r)) < l) begin point(1); l--; end
            else begin point(0); r--; end
        end
        wait_play(1'b0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (actual() !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got %h expected %h", actual(),
                     {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Game 3: random points to the end, then sit in OVER across blink periods.
        pulse_start;
        n = 0;
        while (m_state != 3 && n < 60) begin
            point(int'($urandom % 3));
            n++;
        end
        checks++;
        if (m_state != 3) begin
            errors++;
            $display("FAIL game3_end state %0d expected 3", m_state);
        end
        repeat (900) @(negedge clk);
        pulse_start;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
